// File: rtl/trap_sequencer.sv
// Machine-mode trap/return sequencer. It takes sync exceptions, MRET and the
// external interrupt from the retiring instruction. It flushes and stalls the
// pipeline, writes the trap CSRs one per cycle, then redirects fetch.
module trap_sequencer #(
  parameter int XLEN        = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ret_valid_i,
  input  logic            exc_request_i,
  input  logic            inst_invalid_i,
  input  logic            exc_ret_i,
  input  logic [31:0]     exc_cause_i,
  input  logic [XLEN-1:0] instr_pc_i,
  input  logic [31:0]     instr_bits_i,
  input  logic            irq_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            busy_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [31:0] CAUSE_MEIRQ  = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, RET_MSTAT, REDIRECT
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] cap_pc;
  logic [31:0]     cap_cause;
  logic [31:0]     cap_bits;
  logic [XLEN-1:0] cap_mstatus;
  logic [XLEN-1:0] cap_mtvec;
  logic [XLEN-1:0] cap_mepc;
  logic            cap_mret;

  logic sel_sync, sel_mret, sel_irq, trig;
  logic [XLEN-1:0] trap_target;

  // Trap entry: MPIE takes old MIE, interrupts disabled, previous privilege = M.
  function automatic logic [XLEN-1:0] mstatus_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // MRET: MIE restored from MPIE, MPIE set.
  function automatic logic [XLEN-1:0] mstatus_ret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // mtval carries the bad encoding for illegal instructions, the PC for
  // breakpoints, and zero for everything else.
  function automatic logic [XLEN-1:0] mtval_val(input logic [31:0]     cause,
                                                input logic [XLEN-1:0] pc,
                                                input logic [31:0]     bits);
    if (cause == 32'd2)      return XLEN'(bits);
    else if (cause == 32'd3) return pc;
    else                     return '0;
  endfunction

  // Trigger priority: sync exception, then MRET, then enabled interrupt.
  assign sel_sync = ret_valid_i & (inst_invalid_i | exc_request_i);
  assign sel_mret = ~sel_sync & ret_valid_i & exc_ret_i;
  assign sel_irq  = ~sel_sync & ~sel_mret & irq_i & mstatus_i[3];
  assign trig     = sel_sync | sel_mret | sel_irq;

  // Interrupts use vectored mode only when enabled and mtvec.MODE selects it;
  // synchronous traps always go to the base address.
  assign trap_target = (VECTORED_EN && cap_mtvec[1:0] == 2'b01 && cap_cause[31])
                     ? {cap_mtvec[XLEN-1:2], 2'b00} + XLEN'({cap_cause[30:0], 2'b00})
                     : {cap_mtvec[XLEN-1:2], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the trigger context in IDLE. An interrupt that arrives without a
  // retiring instruction keeps the previously captured PC as its mepc.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_pc      <= '0;
      cap_cause   <= '0;
      cap_bits    <= '0;
      cap_mstatus <= '0;
      cap_mtvec   <= '0;
      cap_mepc    <= '0;
      cap_mret    <= 1'b0;
    end else if (state == IDLE && trig) begin
      if (ret_valid_i) cap_pc <= instr_pc_i;
      cap_cause   <= sel_sync ? exc_cause_i : CAUSE_MEIRQ;
      cap_bits    <= instr_bits_i;
      cap_mstatus <= mstatus_i;
      cap_mtvec   <= mtvec_i;
      cap_mepc    <= mepc_i;
      cap_mret    <= sel_mret;
    end
  end

  // Next-state and Moore outputs; CSR address/data are zero when not writing.
  always_comb begin
    state_nxt        = state;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    busy_o           = (state != IDLE);
    stall_o          = (state != IDLE);
    case (state)
      IDLE:      if (trig) state_nxt = FLUSH;
      FLUSH: begin
        flush_o   = 1'b1;
        state_nxt = cap_mret ? RET_MSTAT : W_MEPC;
      end
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = {cap_pc[XLEN-1:2], 2'b00};
        state_nxt   = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = XLEN'(cap_cause);
        state_nxt   = W_MTVAL;
      end
      W_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MTVAL;
        csr_wdata_o = mtval_val(cap_cause, cap_pc, cap_bits);
        state_nxt   = W_MSTAT;
      end
      W_MSTAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_trap(cap_mstatus);
        state_nxt   = REDIRECT;
      end
      RET_MSTAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_ret(cap_mstatus);
        state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = cap_mret ? cap_mepc : trap_target;
        if (redirect_ready_i) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: cycle-by-cycle expected outputs.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ret_valid_i, exc_request_i, inst_invalid_i, exc_ret_i;
  logic [31:0] exc_cause_i, instr_pc_i, instr_bits_i;
  logic        irq_i;
  logic [31:0] mstatus_i, mtvec_i, mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        flush_o, stall_o, redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  trap_sequencer #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ret_valid_i(ret_valid_i), .exc_request_i(exc_request_i),
    .inst_invalid_i(inst_invalid_i), .exc_ret_i(exc_ret_i),
    .exc_cause_i(exc_cause_i), .instr_pc_i(instr_pc_i),
    .instr_bits_i(instr_bits_i), .irq_i(irq_i),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Move one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the full output bundle against an expected bundle.
  task automatic chk(input string tag, input logic we, input logic [11:0] addr,
                     input logic [31:0] data, input logic fl, input logic rv,
                     input logic [31:0] rpc, input logic bz);
    logic [80:0] obs, exp;
    obs = {csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, stall_o,
           redirect_valid_o, redirect_pc_o, busy_o};
    exp = {we, addr, data, fl, bz, rv, rpc, bz};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic clear_trig();
    ret_valid_i = 0; exc_request_i = 0; inst_invalid_i = 0; exc_ret_i = 0;
    irq_i = 0;
  endtask

  // Checks FLUSH through REDIRECT of a trap with redirect_ready_i=1,
  // starting right after the trigger edge, and the return to IDLE.
  task automatic trap_seq(input string tag, input logic [31:0] mepc,
                          input logic [31:0] cause, input logic [31:0] mtval,
                          input logic [31:0] mstat, input logic [31:0] rpc);
    chk({tag, "_flush"},  1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1); tick();
    chk({tag, "_mepc"},   1'b1, 12'h341, mepc,  1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk({tag, "_mcause"}, 1'b1, 12'h342, cause, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk({tag, "_mtval"},  1'b1, 12'h343, mtval, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk({tag, "_mstat"},  1'b1, 12'h300, mstat, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk({tag, "_redir"},  1'b0, 12'h000, 32'h0, 1'b0, 1'b1, rpc,   1'b1); tick();
    chk_idle({tag, "_done"});
  endtask

  initial begin
    rst = 1; clear_trig();
    exc_cause_i = 0; instr_pc_i = 0; instr_bits_i = 0;
    mstatus_i = 0; mtvec_i = 0; mepc_i = 0; redirect_ready_i = 1;
    tick(); tick();
    chk_idle("reset");
    rst = 0;
    tick();
    chk_idle("post_reset");

    // T1: illegal instruction, MIE=1
    ret_valid_i = 1; inst_invalid_i = 1; exc_cause_i = 32'd2;
    instr_pc_i = 32'h100; instr_bits_i = 32'hFFFF_FFFF;
    mstatus_i = 32'h8; mtvec_i = 32'h200;
    chk_idle("t1_trigger");
    tick(); clear_trig();
    trap_seq("t1", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h200);

    // T2: ECALL with vectored mtvec; sync traps use the base
    ret_valid_i = 1; exc_request_i = 1; exc_cause_i = 32'd11;
    instr_pc_i = 32'h204; instr_bits_i = 32'h0000_0073;
    mstatus_i = 32'h0; mtvec_i = 32'h8000_0001;
    tick(); clear_trig();
    trap_seq("t2", 32'h204, 32'd11, 32'h0, 32'h1800, 32'h8000_0000);

    // T3: interrupt without retiring instr; irq drops mid-sequence
    irq_i = 1; mstatus_i = 32'h8; mtvec_i = 32'h1001;
    tick(); clear_trig();
    trap_seq("t3", 32'h204, 32'h8000_000B, 32'h0, 32'h1880, 32'h102C);
    // irq held with MIE=0 never triggers
    irq_i = 1; mstatus_i = 32'h0;
    tick(); chk_idle("t3_mie0_a");
    tick(); chk_idle("t3_mie0_b");
    tick(); chk_idle("t3_mie0_c");
    irq_i = 0;

    // T4: MRET, MPIE=1/MIE=0
    ret_valid_i = 1; exc_ret_i = 1; instr_pc_i = 32'h300;
    mepc_i = 32'h444; mstatus_i = 32'h80;
    tick(); clear_trig();
    chk("t4_flush", 1'b0, 12'h000, 32'h0,  1'b1, 1'b0, 32'h0,   1'b1); tick();
    chk("t4_mstat", 1'b1, 12'h300, 32'h88, 1'b0, 1'b0, 32'h0,   1'b1); tick();
    chk("t4_redir", 1'b0, 12'h000, 32'h0,  1'b0, 1'b1, 32'h444, 1'b1); tick();
    chk_idle("t4_done");

    // T5: breakpoint (mtval=pc), second trap mid-sequence, slow fetch
    redirect_ready_i = 0;
    ret_valid_i = 1; inst_invalid_i = 1; exc_cause_i = 32'd3;
    instr_pc_i = 32'h500; instr_bits_i = 32'h1234;
    mstatus_i = 32'h8; mtvec_i = 32'h600;
    tick(); clear_trig();
    chk("t5_flush",  1'b0, 12'h000, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1); tick();
    chk("t5_mepc",   1'b1, 12'h341, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1);
    ret_valid_i = 1; exc_request_i = 1; exc_cause_i = 32'd11;
    instr_pc_i = 32'h999; mtvec_i = 32'h7000;
    tick();
    chk("t5_mcause", 1'b1, 12'h342, 32'd3,   1'b0, 1'b0, 32'h0, 1'b1);
    clear_trig(); tick();
    chk("t5_mtval",  1'b1, 12'h343, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk("t5_mstat",  1'b1, 12'h300, 32'h1880, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold%0d", i), 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1);
      tick();
    end
    redirect_ready_i = 1;
    chk("t5_handshake", 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1);
    tick();
    chk_idle("t5_done");

    // T6: reset during W_MCAUSE aborts; captured regs cleared
    ret_valid_i = 1; inst_invalid_i = 1; exc_cause_i = 32'd2;
    instr_pc_i = 32'h700; instr_bits_i = 32'hABCD; mstatus_i = 32'h0;
    mtvec_i = 32'h800;
    tick(); clear_trig();
    chk("t6_flush",  1'b0, 12'h000, 32'h0,   1'b1, 1'b0, 32'h0, 1'b1); tick();
    chk("t6_mepc",   1'b1, 12'h341, 32'h700, 1'b0, 1'b0, 32'h0, 1'b1); tick();
    chk("t6_mcause", 1'b1, 12'h342, 32'd2,   1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1;
    tick();
    chk_idle("t6_reset");
    rst = 0;
    irq_i = 1; mstatus_i = 32'h8; mtvec_i = 32'h2001;
    tick(); clear_trig();
    trap_seq("t6_after", 32'h0, 32'h8000_000B, 32'h0, 32'h1880, 32'h202C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
